// File: rtl/nes_pad_if.sv
// Pad-side and consumer-side signals of the NES pad poll scheduler.
// The slave modport is the scheduler; the master modport drives requests and pad data.
interface nes_pad_if #(
    parameter int NUM_PADS = 2
);
    logic                    poll_req;
    logic [NUM_PADS-1:0]     pad_data;
    logic                    latch;
    logic                    pad_clk;
    logic                    busy;
    logic                    frame_valid;
    logic [8*NUM_PADS-1:0]   btn_state;
    logic [8*NUM_PADS-1:0]   btn_pressed;
    logic [8*NUM_PADS-1:0]   btn_released;

    modport master (
        output poll_req, pad_data,
        input  latch, pad_clk, busy, frame_valid,
        input  btn_state, btn_pressed, btn_released
    );

    modport slave (
        input  poll_req, pad_data,
        output latch, pad_clk, busy, frame_valid,
        output btn_state, btn_pressed, btn_released
    );
endinterface

// File: rtl/nes_pad_scheduler.sv
// Serial poller for NUM_PADS NES pads sharing latch and clock pins.
// Publishes active-high button vectors with press/release pulses once per poll.
module nes_pad_scheduler #(
    parameter int HALF_PERIOD  = 256,
    parameter int FRAME_CYCLES = 524288,
    parameter int NUM_PADS     = 2
) (
    input  logic       clk,
    input  logic       reset,
    nes_pad_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_CLK_LO = 3'd2;
    localparam logic [2:0] S_CLK_HI = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam int TW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] LAT_END = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HP_END  = CW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] T_END   = TW'(FRAME_CYCLES - 1);

    logic [2:0]                 state;
    logic [2:0]                 state_n;
    logic [CW-1:0]              cnt;
    logic [2:0]                 idx;
    logic [TW-1:0]              timer;
    logic                       pending;
    logic [NUM_PADS-1:0]        sync1;
    logic [NUM_PADS-1:0]        sync2;
    logic [NUM_PADS-1:0][7:0]   sh;
    logic [8*NUM_PADS-1:0]      sh_flat;
    logic                       expire;
    logic                       fire;
    logic                       seg_end;

    assign expire  = (timer == T_END);
    assign fire    = expire | bus.poll_req;
    assign sh_flat = sh;

    always_comb begin
        seg_end = 1'b1;
        unique case (state)
            S_LATCH:  seg_end = (cnt == LAT_END);
            S_CLK_LO: seg_end = (cnt == HP_END);
            S_CLK_HI: seg_end = (cnt == HP_END);
            default:  seg_end = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (fire || pending) state_n = S_LATCH;
            S_LATCH:  if (seg_end) state_n = S_CLK_LO;
            S_CLK_LO: if (seg_end) state_n = S_CLK_HI;
            S_CLK_HI: if (seg_end) state_n = (idx == 3'd7) ? S_DONE : S_CLK_LO;
            S_DONE:   state_n = pending ? S_LATCH : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            timer <= expire ? '0 : timer + TW'(1);
            sync1 <= bus.pad_data;
            sync2 <= sync1;
        end
    end

    // A trigger arriving in DONE while a queued poll starts re-queues itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (state_n == S_LATCH && state != S_LATCH) begin
            pending <= (state != S_IDLE) && fire;
        end else if (state != S_IDLE && fire) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == S_IDLE) ? '0 : cnt + CW'(1);
            if (state == S_LATCH) begin
                idx <= '0;
            end else if (state == S_CLK_HI && seg_end) begin
                idx <= idx + 3'd1;
            end
            if (state == S_CLK_LO && seg_end) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    sh[p] <= {sh[p][6:0], ~sync2[p]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.latch        <= 1'b0;
            bus.pad_clk      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.frame_valid  <= 1'b0;
            bus.btn_state    <= '0;
            bus.btn_pressed  <= '0;
            bus.btn_released <= '0;
        end else begin
            bus.latch       <= (state_n == S_LATCH);
            bus.pad_clk     <= (state_n == S_CLK_HI);
            bus.busy        <= (state_n != S_IDLE);
            bus.frame_valid <= (state_n == S_DONE);
            if (state_n == S_DONE) begin
                bus.btn_state    <= sh_flat;
                bus.btn_pressed  <= sh_flat & ~bus.btn_state;
                bus.btn_released <= ~sh_flat & bus.btn_state;
            end else begin
                bus.btn_pressed  <= '0;
                bus.btn_released <= '0;
            end
        end
    end
endmodule
